// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : jk_pkg
//  Description : Shared types and defaults for the JK bank loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        TICK   = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        FORCE  = 3'd5
    } jk_state_t;

    localparam int JK_MAX_RETRY_DEF = 2;

endpackage
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// ============================================================================
//  Module      : jk_excite
//  Description : Minimal JK excitation from target and current Q.
//                Never produces J=K=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_excite #(
    parameter int W = 4
) (
    input  logic [W-1:0] target,
    input  logic [W-1:0] q,
    output logic [W-1:0] j,
    output logic [W-1:0] k
);

    assign j = target & ~q;
    assign k = ~target & q;

endmodule
`default_nettype wire

// File: rtl/jk_loader.sv
`default_nettype none
// ============================================================================
//  Module      : jk_loader
//  Description : Loads a target word into an external JK flip-flop bank
//                with verify/retry. Macro JK_LOADER_FORCE_EN enables a
//                final preset/clear override after retries are exhausted.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_loader
    import jk_pkg::*;
#(
    parameter int W         = 4,
    parameter int MAX_RETRY = JK_MAX_RETRY_DEF
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_data,
    input  logic [W-1:0] q_in,
    output logic [W-1:0] jk_j,
    output logic [W-1:0] jk_k,
    output logic         jk_tick,
    output logic [W-1:0] jk_pr,
    output logic [W-1:0] jk_clr,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int            RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] C_RETRY_MAX = RW'(MAX_RETRY);

    jk_state_t     r_state;
    jk_state_t     w_state_nxt;
    logic [W-1:0]  r_target;
    logic [W-1:0]  r_j;
    logic [W-1:0]  r_k;
    logic [RW-1:0] r_retry_cnt;
    logic          r_forced;
    logic          r_done;
    logic          r_err;

    logic [W-1:0]  w_exc_target;
    logic [W-1:0]  w_j;
    logic [W-1:0]  w_k;
    logic          w_accept;
    logic          w_capture;
    logic          w_retry;
    logic          w_force_set;
    logic          w_done_nxt;
    logic          w_err_nxt;
    logic          w_q_match;

    // On the accept edge the target register is not yet loaded, so excite from req_data.
    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_exc_target = (r_state == IDLE) ? req_data : r_target;
    assign w_q_match    = (q_in == r_target);

    jk_excite #(
        .W (W)
    ) u_excite (
        .target (w_exc_target),
        .q      (q_in),
        .j      (w_j),
        .k      (w_k)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_retry     = 1'b0;
        w_force_set = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = SETUP;
                    w_capture   = 1'b1;
                end
            end
            SETUP:  w_state_nxt = TICK;
            TICK:   w_state_nxt = SETTLE;
            SETTLE: w_state_nxt = CHECK;
            CHECK: begin
                if (w_q_match) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_forced) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end else if (r_retry_cnt < C_RETRY_MAX) begin
                    w_state_nxt = SETUP;
                    w_capture   = 1'b1;
                    w_retry     = 1'b1;
                end else begin
`ifdef JK_LOADER_FORCE_EN
                    w_state_nxt = FORCE;
`else
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
`endif
                end
            end
`ifdef JK_LOADER_FORCE_EN
            FORCE: begin
                w_state_nxt = SETTLE;
                w_force_set = 1'b1;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_target    <= '0;
            r_retry_cnt <= '0;
            r_forced    <= 1'b0;
            r_j         <= '0;
            r_k         <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            if (w_accept) begin
                r_target    <= req_data;
                r_retry_cnt <= '0;
                r_forced    <= 1'b0;
            end
            if (w_retry) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end
            if (w_force_set) begin
                r_forced <= 1'b1;
            end
            // J/K held through SETUP and TICK, dropped for SETTLE.
            if (w_capture) begin
                r_j <= w_j;
                r_k <= w_k;
            end else if (r_state == TICK) begin
                r_j <= '0;
                r_k <= '0;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign jk_tick   = (r_state == TICK);
    assign jk_j      = r_j;
    assign jk_k      = r_k;
    assign done      = r_done;
    assign err       = r_err;

`ifdef JK_LOADER_FORCE_EN
    assign jk_pr  = (r_state == FORCE) ? r_target  : '0;
    assign jk_clr = (r_state == FORCE) ? ~r_target : '0;
`else
    assign jk_pr  = '0;
    assign jk_clr = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_jk_loader
//  Description : Self-checking bench for jk_loader with a behavioural JK bank
//                and a result scoreboard. Honours JK_LOADER_FORCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_loader;

    localparam int W         = 4;
    localparam int MAX_RETRY = 2;

    logic         clk = 1'b0;
    logic         clr;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_data;
    logic [W-1:0] q_in;
    logic [W-1:0] jk_j;
    logic [W-1:0] jk_k;
    logic         jk_tick;
    logic [W-1:0] jk_pr;
    logic [W-1:0] jk_clr;
    logic         busy;
    logic         done;
    logic         err;

    typedef struct {
        logic         is_err;
        int           lat;
        logic [W-1:0] q;
        int           ticks;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] bank_q;
    logic         bank_load;
    logic [W-1:0] bank_val;
    logic         stuck;

    always #5 clk = ~clk;

    jk_loader #(
        .W         (W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .q_in      (q_in),
        .jk_j      (jk_j),
        .jk_k      (jk_k),
        .jk_tick   (jk_tick),
        .jk_pr     (jk_pr),
        .jk_clr    (jk_clr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Behavioural bank: preset/clear override, otherwise JK update on tick.
    always @(posedge clk) begin
        if (bank_load) begin
            bank_q <= bank_val;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (jk_pr[i]) bank_q[i] <= 1'b1;
                else if (jk_clr[i]) bank_q[i] <= 1'b0;
                else if (jk_tick && !(stuck && i == 0)) begin
                    case ({jk_j[i], jk_k[i]})
                        2'b10:   bank_q[i] <= 1'b1;
                        2'b01:   bank_q[i] <= 1'b0;
                        2'b11:   bank_q[i] <= ~bank_q[i];
                        default: bank_q[i] <= bank_q[i];
                    endcase
                end
            end
        end
    end
    assign q_in = bank_q;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bank(input logic [W-1:0] v);
        step();
        bank_load = 1'b1;
        bank_val  = v;
        step();
        bank_load = 1'b0;
    endtask

    task automatic push_exp(input logic e, input int lat, input logic [W-1:0] q, input int t);
        exp_t x;
        x.is_err = e;
        x.lat    = lat;
        x.q      = q;
        x.ticks  = t;
        sb.push_back(x);
    endtask

    // Returns just after the accept edge, i.e. early in cycle 1.
    task automatic start(input logic [W-1:0] d);
        step();
        req_valid = 1'b1;
        req_data  = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n >= 60), 0);
    endtask

    // Monitor: cycle stamps of accepts and ticks, scoreboard compare on done/err.
    initial begin : mon
        int   cyc = 0;
        int   tick_cnt = 0;
        int   accept_q[$];
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr) begin
                accept_q.delete();
                tick_cnt = 0;
            end else begin
                if (busy) chk("jk_overlap", 32'(jk_j & jk_k), 0);
                if (jk_tick) tick_cnt++;
                if (done || err) begin
                    chk("done_err_excl", 32'(done & err), 0);
                    if (sb.size() == 0 || accept_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        a = accept_q.pop_front();
                        chk("result_err", 32'(err), 32'(e.is_err));
                        chk("result_lat", cyc - a, e.lat);
                        chk("result_q", 32'(q_in), 32'(e.q));
                        chk("result_ticks", tick_cnt, e.ticks);
                    end
                end
                if (req_valid && req_ready) begin
                    accept_q.push_back(cyc);
                    tick_cnt = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        clr       = 1'b1;
        req_valid = 1'b1;
        req_data  = 4'hF;
        bank_load = 1'b1;
        bank_val  = '0;
        stuck     = 1'b0;

        // Reset held two cycles with a request pending.
        step();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 1);
        step();
        clr       = 1'b0;
        req_valid = 1'b0;
        bank_load = 1'b0;
        @(negedge clk);
        chk("rst_outs", 32'({jk_j, jk_k, jk_pr, jk_clr, jk_tick, busy, done, err}), 0);
        chk("rst_ready_post", 32'(req_ready), 1);

        // 0000 -> 1010
        set_bank(4'b0000);
        push_exp(1'b0, 5, 4'b1010, 1);
        start(4'b1010);
        @(negedge clk);
        chk("a_setup_j", 32'(jk_j), 32'(4'b1010));
        chk("a_setup_k", 32'(jk_k), 0);
        @(negedge clk);
        chk("a_tick", 32'(jk_tick), 1);
        chk("a_tick_j", 32'(jk_j), 32'(4'b1010));
        @(negedge clk);
        chk("a_settle_jk", 32'({jk_j, jk_k}), 0);
        drain();

        // 1100 -> 1010, then same target again
        set_bank(4'b1100);
        push_exp(1'b0, 5, 4'b1010, 1);
        start(4'b1010);
        @(negedge clk);
        chk("b_setup_j", 32'(jk_j), 32'(4'b0010));
        chk("b_setup_k", 32'(jk_k), 32'(4'b0100));
        drain();
        push_exp(1'b0, 5, 4'b1010, 1);
        start(4'b1010);
        @(negedge clk);
        chk("c_setup_jk", 32'({jk_j, jk_k}), 0);
        drain();

        // Stuck bit0, request 0001
        stuck = 1'b1;
        set_bank(4'b0000);
`ifdef JK_LOADER_FORCE_EN
        push_exp(1'b0, 16, 4'b0001, 3);
`else
        push_exp(1'b1, 13, 4'b0000, 3);
`endif
        start(4'b0001);
        repeat (13) @(negedge clk);
`ifdef JK_LOADER_FORCE_EN
        chk("s_force_pr", 32'(jk_pr), 32'(4'b0001));
        chk("s_force_clr", 32'(jk_clr), 32'(4'b1110));
`else
        chk("s_force_pr", 32'(jk_pr), 0);
        chk("s_force_clr", 32'(jk_clr), 0);
`endif
        drain();
        stuck = 1'b0;

        // clr during TICK
        set_bank(4'b0000);
        start(4'b0110);
        step();
        clr = 1'b1;
        @(negedge clk);
        chk("k_tick_before_clr", 32'(jk_tick), 1);
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("k_outs", 32'({jk_j, jk_k, jk_pr, jk_clr, jk_tick, busy, done, err}), 0);
        chk("k_ready", 32'(req_ready), 1);
        repeat (6) @(negedge clk);

        // Back-to-back with req_valid held
        set_bank(4'b0000);
        push_exp(1'b0, 5, 4'b0011, 1);
        push_exp(1'b0, 5, 4'b0101, 1);
        step();
        req_valid = 1'b1;
        req_data  = 4'b0011;
        step();
        req_data  = 4'b0101;
        repeat (5) @(negedge clk);
        chk("bb_done1", 32'(done), 1);
        chk("bb_ready1", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("bb_done2", 32'(done), 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jk_loader.md
# jk_loader

Sequential loader that drives a bank of W external master-slave JK flip-flops to a requested target word. It computes minimal J/K excitation from the bank's read-back Q, issues a single clock tick to the bank, and verifies the result, retrying on mismatch. It sits between a request source (valid/ready) and a `ffjk` register bank, and is the writing side for state the bank only stores.

## Interface
Parameters:
- `W`, 4: width of the JK bank in bits.
- `MAX_RETRY`, 2: number of re-excitation attempts after the first failed check.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `clr` in 1: reset. Synchronous, active-high. Priority over every other input.
- `req_valid` in 1: a target word is offered.
- `req_ready` out 1: loader is idle. Equal to `state==IDLE`.
- `req_data` in W: target word.
- `q_in` in W: read-back of bank Q outputs.
- `jk_j` out W: J inputs to the bank.
- `jk_k` out W: K inputs to the bank.
- `jk_tick` out 1: one-cycle clock pulse to the bank.
- `jk_pr` out W: per-bit preset to the bank. Active-high.
- `jk_clr` out W: per-bit clear to the bank. Active-high.
- `busy` out 1: a request is in progress.
- `done` out 1: one-cycle pulse on success.
- `err` out 1: one-cycle pulse on failure.

## Operation
- States: IDLE, SETUP, TICK, SETTLE, CHECK, FORCE.
- Transfer occurs on the edge where `req_valid & req_ready`.
  - Latch `req_data` into `target`.
  - Zero `retry_cnt`.
  - Go to SETUP.
- Excitation, per bit, is captured on entry to SETUP from the current `q_in`:
  - `j = target & ~q_in`
  - `k = ~target & q_in`
  - Bits already correct get J=K=0. J=K=1 is never driven.
- SETUP: drive `jk_j`/`jk_k` and hold them. Next state is TICK.
- TICK: `jk_j`/`jk_k` stay held; `jk_tick`=1. Next state is SETTLE.
- SETTLE: `jk_j`/`jk_k`=0. Next state is CHECK.
- CHECK compares `q_in==target`:
  - Match: go to IDLE and pulse `done`.
  - Mismatch with `retry_cnt<MAX_RETRY`: increment `retry_cnt`, recapture excitation, go to SETUP.
  - Mismatch with retries exhausted: behaviour set by the `JK_LOADER_FORCE_EN` macro (see Configuration).
- FORCE: `jk_pr=target` and `jk_clr=~target` for exactly one cycle. Next state is SETTLE, with a `forced` flag set.
- CHECK with `forced` set: match pulses `done`; mismatch pulses `err`. No further retry.
- `done`/`err`:
  - Registered and mutually exclusive.
  - High only in the first IDLE cycle after CHECK.
- `busy`=1 in every state except IDLE.
- `req_valid` is ignored while not IDLE. A new request may be accepted in the same cycle `done`/`err` is high.
- A target equal to the current Q still runs the full sequence, with all J/K=0 and one tick.
- Reset values:
  - State is IDLE, `retry_cnt`=0, `forced`=0, `target`=0.
  - `jk_j`, `jk_k`, `jk_pr`, `jk_clr` = 0.
  - `jk_tick`, `busy`, `done`, `err` = 0.
  - `req_ready`=1.
- `clr` mid-operation: the next cycle is IDLE with all outputs at reset values and no `done`/`err` pulse. The bank is left as-is.

## Timing
- Accept edge is cycle 0.
  - SETUP is cycle 1.
  - TICK is cycle 2.
  - SETTLE is cycle 3.
  - CHECK is cycle 4.
  - `done`/`err` is cycle 5.
- Each retry adds 4 cycles. FORCE adds 3 cycles (FORCE, SETTLE, CHECK).
- Worst case without the macro: 5+4·MAX_RETRY cycles. With the macro: plus 3.
- `jk_j`/`jk_k` are stable across SETUP and TICK, so the bank sees J/K set up one cycle before and held during its tick.
- `q_in` is sampled only at SETUP capture and in CHECK. It must be valid one cycle after `jk_tick` falls.
- `retry_cnt` width is `$clog2(MAX_RETRY+1)`. It saturates and never wraps.

## Configuration
- `JK_LOADER_FORCE_EN` defined: after retries are exhausted, CHECK goes to FORCE (preset/clear override) and then a final check.
- `JK_LOADER_FORCE_EN` undefined: after retries are exhausted, CHECK pulses `err` and returns to IDLE. `jk_pr`/`jk_clr` are tied to 0 and the FORCE state is absent.

## Structure
- Package `jk_pkg` holds:
  - the state enum type `jk_state_t` (IDLE, SETUP, TICK, SETTLE, CHECK, FORCE);
  - the default constant `JK_MAX_RETRY_DEF`=2.
- Sub-module `jk_excite`: combinational, W-bit. Inputs `target` and `q`; outputs `j` and `k`, per the excitation equations above. It is instantiated once in `jk_loader`.

## Test plan
- Reset: hold `clr` for 2 cycles with `req_valid`=1, then release → all outputs 0 and `req_ready`=1, and no request is accepted while `clr`=1.
- Bank model at 0000, request 1010:
  - cycle 1 → `jk_j`=1010, `jk_k`=0000;
  - cycle 2 → `jk_tick`=1;
  - cycle 5 → `done`=1 and `q_in`=1010.
- Bank model at 1100, request 1010 → `jk_j`=0010, `jk_k`=0100, then `done` at cycle 5. Request 1010 again → J=K=0000, one tick, `done` at cycle 5.
- Stuck-bit model (bit0 ignores tick but honours preset), `MAX_RETRY`=2, request 0001:
  - without the macro → 3 ticks, then `err` at cycle 13;
  - with the macro → FORCE at cycle 13 with `jk_pr`=0001 and `jk_clr`=1110, then `done` at cycle 16.
- `clr` asserted during TICK → next cycle IDLE, all outputs 0, no `done`/`err`.
- `req_valid` held high with 0011 then 0101 back-to-back → the second request is accepted in the cycle `done` is high (cycle 5), and the second `done` is at cycle 10.
